// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_if
// Brief    : Operand/control handshake bundle between the ID/EX register and
//            the execute-stage ALU, plus the registered result strobe.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            funct7b0;
  logic            opb5;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_illegal;

  // Upstream side: presents operations, observes results
  modport master (
    output in_valid, alu_op, funct3, funct7b5, funct7b0, opb5, src_a, src_b, flush,
    input  in_ready, out_valid, out_result, out_zero, out_illegal
  );

  // Execute unit side
  modport slave (
    input  in_valid, alu_op, funct3, funct7b5, funct7b0, opb5, src_a, src_b, flush,
    output in_ready, out_valid, out_result, out_zero, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : RV32I execute-stage ALU with optional iterative M-extension
//            (shift-add multiply, restoring divide, 1 bit per cycle).
//            Single-cycle ops retire one per cycle; mul/div hold in_ready low.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);

  localparam int unsigned     SHW    = $clog2(XLEN);
  localparam logic [SHW-1:0]  C_LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] C_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t          state_q,       state_d;
  logic [SHW-1:0]  count_q,       count_d;
  logic [XLEN-1:0] hi_q,          hi_d;        // mul: upper product / div: remainder
  logic [XLEN-1:0] lo_q,          lo_d;        // mul: multiplier / div: dividend->quotient
  logic [XLEN-1:0] opnd_q,        opnd_d;      // multiplicand or divisor magnitude
  logic            neg_q,         neg_d;       // negate product / quotient at the end
  logic            rem_neg_q,     rem_neg_d;   // negate remainder at the end
  logic            sel_hi_q,      sel_hi_d;    // mul: take upper half / div: take remainder
  logic            out_valid_q,   out_valid_d;
  logic [XLEN-1:0] out_result_q,  out_result_d;
  logic            out_zero_q,    out_zero_d;
  logic            out_illegal_q, out_illegal_d;

  // Decode and base-ALU wires
  logic [SHW-1:0]  w_shamt;
  logic            w_dec_r, w_is_m, w_is_ill, w_accept;
  logic [XLEN-1:0] w_base;
  logic            w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_a_sgn, w_b_sgn, w_d_sgn;
  logic            w_div_zero, w_div_ovf;

  // Iteration wires
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN-1:0]   w_mul_hi_n, w_mul_lo_n;
  logic [2*XLEN-1:0] w_mul_prod, w_mul_fix;
  logic [XLEN:0]     w_div_r, w_div_diff;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_rem_n, w_div_quo_n, w_quo_fix, w_rem_fix;
  logic              w_last;

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_zero    = out_zero_q;
  assign bus.out_illegal = out_illegal_q;

  assign w_shamt  = bus.src_b[SHW-1:0];
  assign w_accept = bus.in_valid & (state_q == ST_IDLE) & ~bus.flush;
  // R-type with funct7 bit 0 set selects the M group; bit 5 also set has no meaning
  assign w_dec_r  = (bus.alu_op == 2'b10) & bus.opb5 & bus.funct7b0;
  assign w_is_m   = w_dec_r & ~bus.funct7b5;
  assign w_is_ill = (w_dec_r & bus.funct7b5) | (w_is_m & ~EN_M);

  assign w_a_neg = bus.src_a[XLEN-1];
  assign w_b_neg = bus.src_b[XLEN-1];
  assign w_abs_a = w_a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
  assign w_abs_b = w_b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
  // mulh/mulhsu treat src_a as signed; only mulh treats src_b as signed
  assign w_a_sgn = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b010);
  assign w_b_sgn = (bus.funct3 == 3'b001);
  // div/rem are signed, divu/remu are not
  assign w_d_sgn = ~bus.funct3[0];
  assign w_div_zero = (bus.src_b == '0);
  assign w_div_ovf  = w_d_sgn & (bus.src_a == C_MIN) & (bus.src_b == '1);

  // Single-cycle result for the base integer operations
  always_comb begin
    w_base = '0;
    case (bus.alu_op)
      2'b00: w_base = bus.src_a + bus.src_b;
      2'b01: w_base = bus.src_a - bus.src_b;
      2'b11: w_base = bus.src_b;
      default: begin
        case (bus.funct3)
          3'b000:  w_base = (bus.funct7b5 & bus.opb5) ? (bus.src_a - bus.src_b)
                                                      : (bus.src_a + bus.src_b);
          3'b001:  w_base = bus.src_a << w_shamt;
          3'b010:  w_base = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
          3'b011:  w_base = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
          3'b100:  w_base = bus.src_a ^ bus.src_b;
          3'b101:  w_base = bus.funct7b5 ? XLEN'($signed(bus.src_a) >>> w_shamt)
                                         : (bus.src_a >> w_shamt);
          3'b110:  w_base = bus.src_a | bus.src_b;
          default: w_base = bus.src_a & bus.src_b;
        endcase
      end
    endcase
  end

  // One shift-add step and one restoring-divide step, plus final sign fixes
  always_comb begin
    w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    w_mul_hi_n  = w_mul_sum[XLEN:1];
    w_mul_lo_n  = {w_mul_sum[0], lo_q[XLEN-1:1]};
    w_mul_prod  = {w_mul_hi_n, w_mul_lo_n};
    w_mul_fix   = neg_q ? (~w_mul_prod + 1'b1) : w_mul_prod;
    w_div_r     = {hi_q, lo_q[XLEN-1]};
    w_div_diff  = w_div_r - {1'b0, opnd_q};
    w_div_ge    = ~w_div_diff[XLEN];
    w_div_rem_n = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_r[XLEN-1:0];
    w_div_quo_n = {lo_q[XLEN-2:0], w_div_ge};
    w_quo_fix   = neg_q ? (~w_div_quo_n + 1'b1) : w_div_quo_n;
    w_rem_fix   = rem_neg_q ? (~w_div_rem_n + 1'b1) : w_div_rem_n;
    w_last      = (count_q == C_LAST);
  end

  // Next-state and datapath control; outputs only change on a retire
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    opnd_d        = opnd_q;
    neg_d         = neg_q;
    rem_neg_d     = rem_neg_q;
    sel_hi_d      = sel_hi_q;
    out_valid_d   = 1'b0;
    out_result_d  = out_result_q;
    out_illegal_d = out_illegal_q;

    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_ill) begin
              out_valid_d   = 1'b1;
              out_result_d  = '0;
              out_illegal_d = 1'b1;
            end else if (w_is_m && !bus.funct3[2]) begin
              state_d   = ST_MUL;
              count_d   = '0;
              hi_d      = '0;
              opnd_d    = (w_a_sgn & w_a_neg) ? w_abs_a : bus.src_a;
              lo_d      = (w_b_sgn & w_b_neg) ? w_abs_b : bus.src_b;
              neg_d     = (w_a_sgn & w_a_neg) ^ (w_b_sgn & w_b_neg);
              rem_neg_d = 1'b0;
              sel_hi_d  = (bus.funct3 != 3'b000);
            end else if (w_is_m && w_div_zero) begin
              out_valid_d   = 1'b1;
              out_result_d  = bus.funct3[1] ? bus.src_a : '1;
              out_illegal_d = 1'b0;
            end else if (w_is_m && w_div_ovf) begin
              out_valid_d   = 1'b1;
              out_result_d  = bus.funct3[1] ? '0 : bus.src_a;
              out_illegal_d = 1'b0;
            end else if (w_is_m) begin
              state_d   = ST_DIV;
              count_d   = '0;
              hi_d      = '0;
              lo_d      = (w_d_sgn & w_a_neg) ? w_abs_a : bus.src_a;
              opnd_d    = (w_d_sgn & w_b_neg) ? w_abs_b : bus.src_b;
              neg_d     = w_d_sgn & (w_a_neg ^ w_b_neg);
              rem_neg_d = w_d_sgn & w_a_neg;
              sel_hi_d  = bus.funct3[1];
            end else begin
              out_valid_d   = 1'b1;
              out_result_d  = w_base;
              out_illegal_d = 1'b0;
            end
          end
        end
        ST_MUL: begin
          hi_d    = w_mul_hi_n;
          lo_d    = w_mul_lo_n;
          count_d = count_q + 1'b1;
          if (w_last) begin
            state_d       = ST_IDLE;
            out_valid_d   = 1'b1;
            out_result_d  = sel_hi_q ? w_mul_fix[2*XLEN-1:XLEN] : w_mul_fix[XLEN-1:0];
            out_illegal_d = 1'b0;
          end
        end
        ST_DIV: begin
          hi_d    = w_div_rem_n;
          lo_d    = w_div_quo_n;
          count_d = count_q + 1'b1;
          if (w_last) begin
            state_d       = ST_IDLE;
            out_valid_d   = 1'b1;
            out_result_d  = sel_hi_q ? w_rem_fix : w_quo_fix;
            out_illegal_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Zero flag always tracks the held result
    out_zero_d = (out_result_d == '0);
  end

  // State and output registers; reset discards any partial operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      opnd_q        <= '0;
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
      sel_hi_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_zero_q    <= 1'b1;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      opnd_q        <= opnd_d;
      neg_q         <= neg_d;
      rem_neg_q     <= rem_neg_d;
      sel_hi_q      <= sel_hi_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
    end
  end

endmodule
`default_nettype wire
